// File: rtl/result_queue.sv
// result_queue
// ------------
// Purpose : collects winning nonces from a pool of hashers. Each channel has
//           a one-entry pending register. A fixed-priority arbiter (lowest
//           index wins) moves at most one pending result per cycle into a
//           DEPTH-entry first-word-fall-through queue that the host drains.
// Latency : a success reaches the queue head two edges after it is sampled
//           when the queue is empty and there is no contention. k
//           simultaneous successes arrive over k consecutive edges, in index
//           order.
// Backpressure: halt_out (registered queue-full) asks the pool to stop its
//           nonce counter. While halt_out propagates, each pending register
//           can absorb one more success. Any further success on a busy
//           channel is dropped and recorded in overflow_out and the drop
//           counter.
//
// Optional feature macro: RESULT_QUEUE_STATS_EN
//   defined   -> 16-bit saturating drop counter on drop_count_out
//   undefined -> drop_count_out tied to 16'h0000 (overflow_out always present)
//
// Ports
//   clk_in           : clock, all logic on the rising edge
//   reset_n_in       : synchronous active-low reset (priority over job_start_in)
//   job_start_in     : one-cycle pulse; clears queue, pending, overflow, drops
//   success_in       : per-channel success strobe
//   nonce_in         : shared pool nonce, qualified by any success_in bit
//   result_valid_out : queue head valid
//   result_data_out  : queue head {channel index, nonce}, index in the MSBs
//   result_pop_in    : consume the head (ignored while the queue is empty)
//   ready_out        : queue non-empty (same as result_valid_out)
//   halt_out         : queue full, registered
//   overflow_out     : sticky, at least one result dropped this job
//   drop_count_out   : saturating dropped-result count (macro dependent)

module result_queue #(
  parameter int POOL_SIZE      = 2,
  parameter int POOL_SIZE_LOG2 = 1,
  parameter int DEPTH          = 4,
  parameter int DEPTH_LOG2     = 2
) (
  input  logic                      clk_in,
  input  logic                      reset_n_in,
  input  logic                      job_start_in,
  input  logic [POOL_SIZE-1:0]      success_in,
  input  logic [31-POOL_SIZE_LOG2:0] nonce_in,
  output logic                      result_valid_out,
  output logic [31:0]               result_data_out,
  input  logic                      result_pop_in,
  output logic                      ready_out,
  output logic                      halt_out,
  output logic                      overflow_out,
  output logic [15:0]               drop_count_out
);

  localparam int NONCE_WIDTH = 32 - POOL_SIZE_LOG2;
  // A zero-width channel index is not expressible, so keep at least one bit
  // internally. It is only placed into the result when POOL_SIZE_LOG2 > 0.
  localparam int IDX_W       = (POOL_SIZE_LOG2 > 0) ? POOL_SIZE_LOG2 : 1;
  localparam int CNT_W       = DEPTH_LOG2 + 1;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [POOL_SIZE-1:0]   r_pend_vld;
  logic [NONCE_WIDTH-1:0] r_pend_nonce [POOL_SIZE];
  logic [31:0]            r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0]  r_wr_ptr;
  logic [DEPTH_LOG2-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]       r_count;
  logic                   r_valid;
  logic                   r_halt;
  logic                   r_overflow;

  // ---------------------------------------------------------------------------
  // Combinational control
  // ---------------------------------------------------------------------------
  logic                   w_clr;
  logic                   w_any;
  logic [IDX_W-1:0]       w_sel_idx;
  logic [NONCE_WIDTH-1:0] w_sel_nonce;
  logic [31:0]            w_push_dat;
  logic                   w_full;
  logic                   w_empty;
  logic                   w_pop;
  logic                   w_push;
  logic [POOL_SIZE-1:0]   w_drain;
  logic [POOL_SIZE-1:0]   w_load;
  logic [POOL_SIZE-1:0]   w_drop;
  logic [CNT_W-1:0]       w_count_nxt;

  // Reset and job start have the same clearing effect. Both also mask the
  // same-cycle success and pop.
  assign w_clr = !reset_n_in || job_start_in;

  // Fixed-priority arbiter: scan from the top so that the lowest valid index
  // is the last assignment and wins.
  always_comb begin
    w_any       = 1'b0;
    w_sel_idx   = '0;
    w_sel_nonce = '0;
    for (int i = POOL_SIZE - 1; i >= 0; i--) begin
      if (r_pend_vld[i]) begin
        w_any       = 1'b1;
        w_sel_idx   = IDX_W'(i);
        w_sel_nonce = r_pend_nonce[i];
      end
    end
  end

  generate
    if (POOL_SIZE_LOG2 > 0) begin : g_idx
      assign w_push_dat = {w_sel_idx[POOL_SIZE_LOG2-1:0], w_sel_nonce};
    end else begin : g_no_idx
      assign w_push_dat = 32'(w_sel_nonce);
    end
  endgenerate

  assign w_full  = (r_count == CNT_W'(DEPTH));
  assign w_empty = (r_count == '0);

  // A pop on an empty queue is ignored entirely.
  assign w_pop  = result_pop_in && !w_empty && !w_clr;
  // When the queue is full, a same-cycle pop frees the slot that the push
  // then takes. Count stays at DEPTH and both pointers advance.
  assign w_push = w_any && (!w_full || w_pop) && !w_clr;

  // A channel that is drained this cycle can accept a new success in the
  // same cycle without losing anything.
  always_comb begin
    w_drain = '0;
    w_load  = '0;
    w_drop  = '0;
    for (int i = 0; i < POOL_SIZE; i++) begin
      w_drain[i] = w_push && (w_sel_idx == IDX_W'(i));
      w_load[i]  = !w_clr && success_in[i] && (!r_pend_vld[i] || w_drain[i]);
      w_drop[i]  = !w_clr && success_in[i] && r_pend_vld[i] && !w_drain[i];
    end
  end

  assign w_count_nxt = r_count + CNT_W'(w_push) - CNT_W'(w_pop);

  // ---------------------------------------------------------------------------
  // Control registers (cleared by reset or job start)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_in) begin
    if (w_clr) begin
      r_pend_vld <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_valid    <= 1'b0;
      r_halt     <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_pend_vld <= (r_pend_vld & ~w_drain) | w_load;
      // DEPTH is a power of two, so natural pointer overflow wraps modulo DEPTH.
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + DEPTH_LOG2'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + DEPTH_LOG2'(1);
      end
      r_count <= w_count_nxt;
      // Flags are registered from the next count. They therefore always
      // match the count register that they accompany.
      r_valid <= (w_count_nxt != '0);
      r_halt  <= (w_count_nxt == CNT_W'(DEPTH));
      if (|w_drop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Data storage (not reset; validity is carried by the control registers)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_in) begin
    for (int i = 0; i < POOL_SIZE; i++) begin
      if (w_load[i]) begin
        r_pend_nonce[i] <= nonce_in;
      end
    end
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_push_dat;
    end
  end

  // ---------------------------------------------------------------------------
  // Drop statistics
  // ---------------------------------------------------------------------------
`ifdef RESULT_QUEUE_STATS_EN
  logic [15:0] r_drop_cnt;
  logic [4:0]  w_drop_num;
  logic [16:0] w_drop_sum;

  // Several channels can drop in the same cycle. Each dropped channel counts once.
  always_comb begin
    w_drop_num = '0;
    for (int i = 0; i < POOL_SIZE; i++) begin
      w_drop_num = w_drop_num + 5'(w_drop[i]);
    end
  end

  assign w_drop_sum = {1'b0, r_drop_cnt} + 17'(w_drop_num);

  always_ff @(posedge clk_in) begin
    if (w_clr) begin
      r_drop_cnt <= '0;
    end else if (w_drop_sum[16]) begin
      r_drop_cnt <= 16'hFFFF;
    end else begin
      r_drop_cnt <= w_drop_sum[15:0];
    end
  end

  assign drop_count_out = r_drop_cnt;
`else
  assign drop_count_out = 16'h0000;
`endif

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign result_valid_out = r_valid;
  assign ready_out        = r_valid;
  assign halt_out         = r_halt;
  assign overflow_out     = r_overflow;
  // The head is gated so that an empty queue presents zero rather than stale
  // memory contents.
  assign result_data_out  = r_valid ? r_mem[r_rd_ptr] : 32'h0;

endmodule

// File: tb/tb_result_queue.sv
module tb_result_queue;
  localparam int PS  = 2;
  localparam int PL2 = 1;
  localparam int D   = 4;
  localparam int DL2 = 2;
  localparam int NW  = 32 - PL2;

  logic          clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset_n = 1'b0;
  logic          js      = 1'b0;
  logic          pop     = 1'b0;
  logic [PS-1:0] succ    = '0;
  logic [NW-1:0] nonce   = '0;
  logic          valid, ready, halt, ovf;
  logic [31:0]   data;
  logic [15:0]   drop;

  result_queue #(.POOL_SIZE(PS), .POOL_SIZE_LOG2(PL2), .DEPTH(D), .DEPTH_LOG2(DL2)) dut (
    .clk_in(clk), .reset_n_in(reset_n), .job_start_in(js), .success_in(succ),
    .nonce_in(nonce), .result_valid_out(valid), .result_data_out(data),
    .result_pop_in(pop), .ready_out(ready), .halt_out(halt),
    .overflow_out(ovf), .drop_count_out(drop));

  int checks   = 0;
  int failures = 0;
  bit mon_en   = 1'b0;

  // Reference model: results in queue order plus per-channel pending slots.
  logic [31:0]   sb[$];
  int            m_count = 0;
  bit            m_pvld[PS];
  logic [NW-1:0] m_pn[PS];
  bit            m_ovf   = 1'b0;
  int            m_drops = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Model update at each edge, using the inputs that are stable across it.
  always @(posedge clk) begin
    int c;
    bit popped;
    if (!reset_n || js) begin
      sb.delete();
      m_count = 0;
      for (int i = 0; i < PS; i++) m_pvld[i] = 1'b0;
      m_ovf   = 1'b0;
      m_drops = 0;
    end else begin
      popped = pop && (m_count > 0);
      c = -1;
      for (int i = PS - 1; i >= 0; i--) if (m_pvld[i]) c = i;
      if (c >= 0 && (m_count < D || popped)) begin
        sb.push_back((32'(c) << NW) | 32'(m_pn[c]));
        m_count++;
        m_pvld[c] = 1'b0;
      end
      for (int i = 0; i < PS; i++) begin
        if (succ[i]) begin
          if (!m_pvld[i]) begin
            m_pvld[i] = 1'b1;
            m_pn[i]   = nonce;
          end else begin
            m_ovf = 1'b1;
            if (m_drops < 65535) m_drops++;
          end
        end
      end
      if (popped) m_count--;
    end
  end

  // Monitor: status every cycle; head data checked against the scoreboard
  // whenever a pop is about to consume it.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("valid", 32'(valid), 32'(m_count != 0));
      chk("ready", 32'(ready), 32'(m_count != 0));
      chk("halt", 32'(halt), 32'(m_count == D));
      chk("overflow", 32'(ovf), 32'(m_ovf));
`ifdef RESULT_QUEUE_STATS_EN
      chk("drop_count", 32'(drop), 32'(m_drops));
`else
      chk("drop_count", 32'(drop), 32'd0);
`endif
      if (valid && pop && reset_n && !js) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL pop_data: got 0x%08h expected none (scoreboard empty)", data);
        end else begin
          chk("pop_data", data, sb.pop_front());
        end
      end
    end
  end

  task automatic cyc(input bit rn, input bit j, input logic [PS-1:0] s,
                     input logic [NW-1:0] n, input bit p);
    reset_n = rn; js = j; succ = s; nonce = n; pop = p;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cyc(1'b1, 1'b0, '0, '0, 1'b0);
  endtask

  initial begin
    int n;
    // Reset hold
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, '0, '0, 1'b0);
    mon_en = 1'b1;
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_ready", 32'(ready), 32'd0);
    chk("rst_halt", 32'(halt), 32'd0);
    chk("rst_overflow", 32'(ovf), 32'd0);
    chk("rst_drop", 32'(drop), 32'd0);
    chk("rst_data", data, 32'd0);

    // Single success: two-edge latency
    cyc(1'b1, 1'b0, 2'b01, NW'(32'h0000_1234), 1'b0);
    chk("lat_edge1_valid", 32'(valid), 32'd0);
    idle();
    chk("lat_edge2_valid", 32'(valid), 32'd1);
    chk("lat_data", data, 32'h0000_1234);
    chk("lat_ready", 32'(ready), 32'd1);
    cyc(1'b1, 1'b0, '0, '0, 1'b1);
    chk("pop_empty_valid", 32'(valid), 32'd0);

    // Simultaneous wins: index order, channel index in the MSB
    cyc(1'b1, 1'b0, 2'b11, NW'(32'h7ABC_DEF0), 1'b0);
    idle();
    chk("dual_first", data, 32'h7ABC_DEF0);
    idle();
    cyc(1'b1, 1'b0, '0, '0, 1'b1);
    chk("dual_second", data, 32'hFABC_DEF0);
    cyc(1'b1, 1'b0, '0, '0, 1'b1);
    chk("dual_empty", 32'(valid), 32'd0);

    // Five successes into a 4-deep queue
    for (int k = 1; k <= 5; k++) cyc(1'b1, 1'b0, 2'b01, NW'(k), 1'b0);
    idle();
    chk("full_halt", 32'(halt), 32'd1);
    chk("full_head", data, 32'd1);
    cyc(1'b1, 1'b0, '0, '0, 1'b1);
    chk("full_pushpop_halt", 32'(halt), 32'd1);
    chk("full_pushpop_head", data, 32'd2);

    // Queue full, pending full, then a third success on channel 0 is dropped
    cyc(1'b1, 1'b0, 2'b01, NW'(6), 1'b0);
    cyc(1'b1, 1'b0, 2'b01, NW'(7), 1'b0);
    chk("drop_overflow", 32'(ovf), 32'd1);
`ifdef RESULT_QUEUE_STATS_EN
    chk("drop_count_1", 32'(drop), 32'd1);
`else
    chk("drop_count_1", 32'(drop), 32'd0);
`endif
    chk("drop_head_kept", data, 32'd2);
    n = 0;
    while (valid && n < 20) begin
      cyc(1'b1, 1'b0, '0, '0, 1'b1);
      n++;
    end
    chk("drain_len", 32'(n), 32'd5);

    // Push and pop at the same edge with count=1
    cyc(1'b1, 1'b0, 2'b01, NW'(32'hA), 1'b0);
    cyc(1'b1, 1'b0, 2'b01, NW'(32'hB), 1'b0);
    cyc(1'b1, 1'b0, '0, '0, 1'b1);
    chk("cnt1_pushpop_valid", 32'(valid), 32'd1);
    chk("cnt1_pushpop_data", data, 32'hB);
    cyc(1'b1, 1'b0, '0, '0, 1'b1);

    // Job start with three queued entries and a simultaneous success
    cyc(1'b1, 1'b0, 2'b11, NW'(32'h100), 1'b0);
    cyc(1'b1, 1'b0, 2'b01, NW'(32'h200), 1'b0);
    idle();
    idle();
    chk("js_pre_valid", 32'(valid), 32'd1);
    cyc(1'b1, 1'b1, 2'b11, NW'(32'h55), 1'b1);
    chk("js_valid", 32'(valid), 32'd0);
    chk("js_halt", 32'(halt), 32'd0);
    chk("js_overflow", 32'(ovf), 32'd0);
    chk("js_drop", 32'(drop), 32'd0);
    chk("js_data", data, 32'd0);
    idle();
    idle();
    chk("js_not_captured", 32'(valid), 32'd0);

    // Randomised traffic with varying pop pressure
    for (int ph = 0; ph < 3; ph++) begin
      for (int i = 0; i < 1000; i++) begin
        cyc($urandom_range(0, 499) != 0, $urandom_range(0, 199) == 0,
            PS'($urandom), NW'($urandom), $urandom_range(0, 3) < ph + 1);
      end
    end

    // Bounded final drain
    n = 0;
    while (valid && n < 50) begin
      cyc(1'b1, 1'b0, '0, '0, 1'b1);
      n++;
    end
    idle();
    idle();
    n = 0;
    while (valid && n < 50) begin
      cyc(1'b1, 1'b0, '0, '0, 1'b1);
      n++;
    end
    chk("final_empty", 32'(valid), 32'd0);
    mon_en = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/result_queue.md
# result_queue

Parametrised result collector between the hasher pool and the external IO block. It replaces the single-nonce, single-success result path with a per-channel capture stage and a fixed-priority arbiter feeding a DEPTH-entry first-word-fall-through queue. Multiple winning nonces per job, including simultaneous wins from different hashers, are held until the host reads them, and the device's ready signal is driven from queue occupancy.

## Interface
- POOL_SIZE, 2, number of hasher channels (power of two, 1..16)
- POOL_SIZE_LOG2, 1, log2(POOL_SIZE); 0 allowed when POOL_SIZE=1
- DEPTH, 4, queue entries (power of two, 2..32)
- DEPTH_LOG2, 2, log2(DEPTH)
- NONCE_WIDTH is derived locally as 32-POOL_SIZE_LOG2.

Ports:
- clk_in, input, 1, single clock for the block, all logic rising-edge
- reset_n_in, input, 1, synchronous active-low reset, sampled on rising clk_in
- job_start_in, input, 1, one-cycle pulse; new job loaded, clears all state
- success_in, input, POOL_SIZE, per-channel success strobe; bit i = hasher i met difficulty this cycle
- nonce_in, input, NONCE_WIDTH, shared pool nonce value qualified by any success_in bit
- result_valid_out, output, 1, queue head valid
- result_data_out, output, 32, queue head {channel index[POOL_SIZE_LOG2-1:0], nonce[NONCE_WIDTH-1:0]}; channel index occupies the MSBs
- result_pop_in, input, 1, consume head when result_valid_out=1
- ready_out, output, 1, queue non-empty; drives the tri-state ready_n line at top level
- halt_out, output, 1, queue full; pool stalls its nonce counter while high
- overflow_out, output, 1, sticky: at least one result was dropped this job
- drop_count_out, output, 16, saturating count of dropped results (see Configuration)

## Operation
- Capture stage: one pending register per channel, holding a valid bit and NONCE_WIDTH bits.
  - If success_in[i]=1 and pending[i] is empty, or is being drained this cycle, load nonce_in and set pending[i].valid.
  - If success_in[i]=1 and pending[i] is full and not being drained, drop the result, set overflow_out, and increment the drop counter by 1 per dropped channel-event (saturating).
- Arbiter: each cycle, select the lowest-index valid pending channel.
  - Push it to the queue when not full, or when full with a pop in the same cycle.
  - Pushing clears pending[i].valid.
  - One push per cycle maximum.
- Queue: circular buffer with DEPTH_LOG2-bit read and write pointers plus a (DEPTH_LOG2+1)-bit count.
  - Pointers wrap modulo DEPTH.
  - result_data_out = mem[rd_ptr] whenever count != 0.
- Pop: result_pop_in with count=0 is ignored, with no underflow and no pointer motion.
- Simultaneous push and pop: count unchanged, both pointers advance. Legal at full and at count=1.
- job_start_in: the next edge clears queue, pending, overflow_out, and drop counter. success_in in the same cycle is ignored. result_pop_in in the same cycle is ignored.
- Reset (reset_n_in=0 at an edge) has the same effect as job_start_in and takes priority over it. Mid-operation reset discards all queued and pending results.
- Memory contents are not reset; only pointers, count, and valid bits are.

## Timing
- Reset values: result_valid_out=0, result_data_out=don't-care (0 in simulation), ready_out=0, halt_out=0, overflow_out=0, drop_count_out=0.
- Latency with the queue empty and no contention: success_in high at edge t, pending set at t, push at t+1, result_valid_out=1 after edge t+1. That is 2 edges total.
- Contention: k simultaneous successes reach the queue over k consecutive edges, in index order.
- ready_out and result_valid_out are identical, registered from count.
- halt_out is registered: high in the cycle after count reaches DEPTH, low in the cycle after the first pop from full.
- Pending registers absorb at most one further success per channel while halt_out propagates.
- Pop takes effect at the edge. The new head appears on result_data_out the following cycle.

## Configuration
- RESULT_QUEUE_STATS_EN defined: 16-bit saturating drop counter implemented. It saturates at 16'hFFFF and clears on reset or job_start_in.
- RESULT_QUEUE_STATS_EN undefined: no counter logic; drop_count_out tied to 16'h0000. overflow_out is always implemented.

## Test plan
- Reset hold, then success_in=2'b01, nonce_in=0x0000_1234 (POOL_SIZE=2): result_valid_out high after 2 edges, result_data_out=0x0000_1234, ready_out=1. Pop gives result_valid_out=0 next cycle.
- success_in=2'b11 in one cycle, nonce_in=0x7ABCDEF0: two entries in order, 0x7ABCDEF0 then 0xFABCDEF0 (channel 1 in MSB).
- Five single successes, no pops, DEPTH=4: halt_out=1, fifth result held in pending. First pop pushes it and count stays 4. Drain returns 5 entries in order.
- Queue full, pending full, third success on the same channel: overflow_out=1, drop_count_out=1 (0 with macro off), queue contents unchanged.
- Push and pop in the same cycle at full and at count=1: count constant, pointer wrap at DEPTH-1→0 verified, no data corruption.
- job_start_in asserted with 3 queued entries and a simultaneous success_in: all outputs return to reset values, and the simultaneous success is not captured.
